// File: rtl/uart_cmd_controller_if.sv
// Handshake bundle between the command controller, the UART rx/tx pair and the register bus.
// The master side is the controller; the slave side is the UART plus register file.
interface uart_cmd_controller_if #(
  parameter int ADDR_W = 4
) ();

  logic              rx_ready;
  logic [7:0]        rx_data;

  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;

  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport master (
    input  rx_ready, rx_data, reg_rdata, tx_busy,
    output reg_wr_en, reg_rd_en, reg_addr, reg_wdata, tx_start, tx_data
  );

  modport slave (
    output rx_ready, rx_data, reg_rdata, tx_busy,
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata, tx_start, tx_data
  );

endinterface

// File: rtl/uart_cmd_controller.sv
// Parses 'W'/'R' register-access frames from the UART receiver, drives the register bus
// and queues a one-byte reply (ACK, NAK or read data) to the UART transmitter.
module uart_cmd_controller #(
  parameter int         ADDR_W        = 4,
  parameter int         TIMEOUT_TICKS = 320,
  parameter logic [7:0] OP_WR         = 8'h57,
  parameter logic [7:0] OP_RD         = 8'h52,
  parameter logic [7:0] ACK           = 8'h06,
  parameter logic [7:0] NAK           = 8'h15
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  sample_tick,
  uart_cmd_controller_if.master bus,
  output logic [7:0]            err_count
);

  localparam int                TICK_W    = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    READ_WAIT,
    SEND,
    WAIT_TX
  } state_t;

  state_t            state;
  logic              is_write;
  logic [TICK_W-1:0] tick_count;
  logic [7:0]        reply_byte;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Strobes default low each cycle so every pulse lasts exactly one clock.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state         <= IDLE;
      is_write      <= 1'b0;
      tick_count    <= '0;
      reply_byte    <= 8'h00;
      err_count     <= 8'h00;
      bus.reg_wr_en <= 1'b0;
      bus.reg_rd_en <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= 8'h00;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= 8'h00;
    end else begin
      bus.reg_wr_en <= 1'b0;
      bus.reg_rd_en <= 1'b0;
      bus.tx_start  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rx_ready) begin
            tick_count <= '0;
            if (bus.rx_data == OP_WR) begin
              is_write <= 1'b1;
              state    <= GET_ADDR;
            end else if (bus.rx_data == OP_RD) begin
              is_write <= 1'b0;
              state    <= GET_ADDR;
            end else begin
              reply_byte <= NAK;
              err_count  <= sat_inc(err_count);
              state      <= SEND;
            end
          end
        end

        // A byte in the same cycle as the final tick still counts; the timeout only fires without one.
        GET_ADDR, GET_DATA: begin
          if (bus.rx_ready) begin
            tick_count <= '0;
            if (state == GET_ADDR) begin
              bus.reg_addr <= bus.rx_data[ADDR_W-1:0];
              state        <= is_write ? GET_DATA : READ;
            end else begin
              bus.reg_wdata <= bus.rx_data;
              state         <= WRITE;
            end
          end else if (sample_tick) begin
            if (tick_count == LAST_TICK) begin
              tick_count <= '0;
              err_count  <= sat_inc(err_count);
              state      <= IDLE;
            end else begin
              tick_count <= tick_count + TICK_W'(1);
            end
          end
        end

        WRITE: begin
          bus.reg_wr_en <= 1'b1;
          reply_byte    <= ACK;
          state         <= SEND;
        end

        READ: begin
          bus.reg_rd_en <= 1'b1;
          state         <= READ_WAIT;
        end

        // Read data lags the strobe by one cycle, so skip the cycle where the strobe is still high.
        READ_WAIT: begin
          if (!bus.reg_rd_en) begin
            reply_byte <= bus.reg_rdata;
            state      <= SEND;
          end
        end

        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= reply_byte;
            state        <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (bus.tx_busy) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (bus.rx_ready && !(state inside {IDLE, GET_ADDR, GET_DATA})) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule
